// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// one-hot op bit positions and the controller state encoding.
package muldiv_pkg;

  localparam int OP_MULT  = 3;
  localparam int OP_MULTU = 2;
  localparam int OP_DIV   = 1;
  localparam int OP_DIVU  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: radix-2 shift-add (multiply) or
// restoring trial-subtract (divide) on a 2*WIDTH accumulator.
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               mode_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: acc = {remainder, dividend bits still to shift in / quotient bits}
    trial   = acc_i[2*WIDTH-1:WIDTH-1];
    diff    = trial - {1'b0, operand};
    if (mode_div) begin
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied in FIX.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_mult;
  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] step_acc;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div),
    .acc_i    (acc_q),
    .operand  (b_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    is_mult   = op_q[OP_MULT] | op_q[OP_MULTU];
    is_div    = op_q[OP_DIV]  | op_q[OP_DIVU];
    is_signed = op_q[OP_MULT] | op_q[OP_DIV];
    mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_wen) hi_d = wdata;
        if (lo_wen) lo_d = wdata;
        if (start && $onehot(op) && !flush) begin
          state_d = S_PREP;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
        end
      end
      S_PREP: begin
        neg_res_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = is_signed & a_q[WIDTH-1];
        cnt_d     = '0;
        // a_q keeps the original dividend for the divide-by-zero result;
        // b_q becomes the per-iteration operand (multiplicand or divisor).
        if (is_mult) begin
          acc_d = {{WIDTH{1'b0}}, mag_b};
          b_d   = mag_a;
        end else begin
          acc_d = {{WIDTH{1'b0}}, mag_a};
          b_d   = mag_b;
        end
        state_d = S_CALC;
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div) begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort keeps HI/LO as they were; an IDLE MTHI/MTLO still lands.
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: the driver queues expected HI/LO and
// done cycle from an arithmetic model; a negedge monitor checks each done.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b, wdata;
  logic         hi_wen, lo_wen, flush;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi_wen (hi_wen),
    .lo_wen (lo_wen),
    .wdata  (wdata),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hi_m, lo_m;
  logic         prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic with truncating signed division.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] res;
    res = '0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (o[OP_MULT]) res = 64'(sa * sbv);
    else if (o[OP_MULTU]) res = {32'b0, a} * {32'b0, b};
    else if (b == '0) res = {a, 32'hFFFF_FFFF};
    else if (o[OP_DIV]) begin
      q = sa / sbv;
      r = sa % sbv;
      res = {r[31:0], q[31:0]};
    end else res = {a % b, a / b};
    return res;
  endfunction

  function automatic logic [3:0] sel(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk("done_single_cycle", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
          chk({e.name, "_busy_in_done"}, 64'(busy), 64'd0);
          $display("TXN %s hi=%h lo=%h cycle=%0d", e.name, hi, lo, cyc);
        end
      end
      prev_done = done;
    end
  end

  task automatic launch(input string name, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit push, input bit now);
    logic [63:0] r;
    if (!now) @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (push) begin
      r = model(o, a, b);
      sb.push_back('{hi: r[63:32], lo: r[31:0], due: cyc + 1 + LAT, name: name});
      hi_m = r[63:32];
      lo_m = r[31:0];
    end
    @(negedge clk);
    start = 1'b0; op = 4'b0000;
  endtask

  // Ends on the negedge where done is high; counts busy samples before it.
  task automatic wait_done(input string name, input bit check_busy);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done want done within 200 cycles", name);
    end else if (check_busy) begin
      chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] saved_hi;
    logic [3:0]   o;
    logic [W-1:0] a, b;
    int           kind;

    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0; flush = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b1;

    launch("mult_m3x7", sel(OP_MULT), 32'hFFFF_FFFD, 32'h0000_0007, 1, 0);
    wait_done("mult_m3x7", 1);

    launch("multu_max", sel(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    wait_done("multu_max", 1);
    launch("multu_b2b", sel(OP_MULTU), 32'd2, 32'd3, 1, 1);
    wait_done("multu_b2b", 1);

    launch("div_m7d2", sel(OP_DIV), 32'hFFFF_FFF9, 32'h0000_0002, 1, 0);
    wait_done("div_m7d2", 1);
    launch("div_ovf", sel(OP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    wait_done("div_ovf", 1);
    launch("divu_by0", sel(OP_DIVU), 32'h0000_0007, 32'h0, 1, 0);
    wait_done("divu_by0", 1);
    launch("div_by0", sel(OP_DIV), 32'h8000_0000, 32'h0, 1, 0);
    wait_done("div_by0", 1);

    // MTHI/MTLO in IDLE, then a MULT aborted on its 10th cycle.
    @(negedge clk);
    hi_wen = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_wen = 1'b0; lo_wen = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    lo_wen = 1'b0;
    hi_m = 32'h1234_5678; lo_m = 32'h9ABC_DEF0;
    chk("mthi", 64'(hi), 64'(hi_m));
    chk("mtlo", 64'(lo), 64'(lo_m));
    launch("mult_flushed", sel(OP_MULT), 32'h0000_1234, 32'h0000_5678, 0, 1);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi", 64'(hi), 64'(hi_m));
    chk("flush_lo", 64'(lo), 64'(lo_m));

    // Flush in IDLE drops a same-edge start but keeps the MTHI.
    flush = 1'b1; hi_wen = 1'b1; wdata = 32'hA5A5_5A5A;
    start = 1'b1; op = sel(OP_MULTU); src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    flush = 1'b0; hi_wen = 1'b0; start = 1'b0; op = '0;
    hi_m = 32'hA5A5_5A5A;
    chk("flush_start_busy", 64'(busy), 64'd0);
    chk("flush_mthi", 64'(hi), 64'(hi_m));

    // MTHI while busy must be ignored.
    saved_hi = hi;
    launch("divu_mthi_busy", sel(OP_DIVU), 32'd1000, 32'd7, 1, 0);
    repeat (5) @(negedge clk);
    hi_wen = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_wen = 1'b0;
    chk("mthi_busy_ignored", 64'(hi), 64'(saved_hi));
    wait_done("divu_mthi_busy", 0);

    // Reset part-way through a DIVU.
    launch("divu_reset", sel(OP_DIVU), 32'hFFFF_0000, 32'd3, 0, 0);
    repeat (18) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hi_m = '0; lo_m = '0;
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    launch("multihot", 4'b0011, 32'd9, 32'd3, 0, 0);
    chk("multihot_busy", 64'(busy), 64'd0);
    launch("zero_op", 4'b0000, 32'd9, 32'd3, 0, 0);
    chk("zero_op_busy", 64'(busy), 64'd0);

    for (int n = 0; n < 24; n++) begin
      o = sel($urandom_range(0, 3));
      a = $urandom;
      kind = $urandom_range(0, 7);
      case (kind)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      launch($sformatf("rand%0d_op%b", n, o), o, a, b, 1, 0);
      wait_done($sformatf("rand%0d", n), 1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("final_hi", 64'(hi), 64'(hi_m));
    chk("final_lo", 64'(lo), 64'(lo_m));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
